mem_block_mover: RTL and testbench

- Bus initiator that drives the DataMemory port (address/read/write/data_inputs, with data_outputs returned) to perform block copy or block fill.
- The CPU control path programs source, destination, length and mode, pulses start, then waits for done.
- Sits between the control unit and DataMemory. It is muxed onto the memory port while busy is high.

---
 rtl/mem_block_mover.sv | 140 ++++++++++++++
 tb/tb_mem_block_mover.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_mover.sv
// Block copy / block fill bus initiator for the DataMemory port.
// Moore-style FSM: memory strobes decode from state, each word is read, latched, then written.
module mem_block_mover #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_next;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] fill_q;
    logic [DATA_WIDTH-1:0] data_buf;
    logic                  last_word;

    assign last_word = (idx == (len_q - ONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            fill_q   <= '0;
            data_buf <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        len_q  <= length;
                        fill_q <= fill_value;
                        idx    <= '0;
                    end
                end
                LATCH: data_buf <= mem_rdata;
                WRITE: begin
                    if (!last_word) begin
                        idx <= idx + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_next = DONE;
                    end else if (mode) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                busy        = 1'b1;
                mem_read    = 1'b1;
                mem_address = src_q + idx;
                state_next  = LATCH;
            end
            LATCH: begin
                busy       = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                mem_write   = 1'b1;
                mem_address = dst_q + idx;
                mem_wdata   = mode_q ? fill_q : data_buf;
                if (last_word) begin
                    state_next = DONE;
                end else if (mode_q) begin
                    state_next = WRITE;
                end else begin
                    state_next = READ;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Outputs are forced low while reset is held so an aborting edge cannot commit a write.
        if (reset) begin
            busy        = 1'b0;
            done        = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            mem_address = '0;
            mem_wdata   = '0;
        end
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: DataMemory model, transaction-level reference model and per-cycle checker.
module tb_mem_block_mover;

    logic       clk = 1'b0;
    logic       reset, start, mode;
    logic [7:0] src_addr, dst_addr, length, fill_value;
    logic       busy, done, mem_read, mem_write;
    logic [7:0] mem_address, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;

    mem_block_mover #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_value(fill_value), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem[256];
    logic [7:0] ref_mem[256];
    logic [7:0] wr_log[$];
    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    int         done_count = 0;
    int         done_cyc = 0;
    int         start_cyc = 0;

    // DataMemory: address/read sampled on the edge, write commits on the edge.
    always @(posedge clk) begin
        if (mem_read === 1'b1) mem_rdata <= mem[mem_address];
        if (mem_write === 1'b1) mem[mem_address] <= mem_wdata;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (reset === 1'b1 || exp_q.size() == 0) e = '0;
        else e = exp_q.pop_front();
        ok = (busy === e.busy) && (done === e.done) &&
             (mem_read === e.rd) && (mem_write === e.wr);
        if (e.rd || e.wr) ok = ok && (mem_address === e.addr);
        if (e.wr) ok = ok && (mem_wdata === e.wdata);
        checks++;
        if (ok) passes++;
        else $display("FAIL cycle_outputs @%0d: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h, expected busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h",
                      cyc, busy, done, mem_read, mem_write, mem_address, mem_wdata,
                      e.busy, e.done, e.rd, e.wr, e.addr, e.wdata);
        if (e.wr) ref_mem[e.addr] = e.wdata;
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
        if (mem_write === 1'b1) wr_log.push_back(mem_address);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic chk_mem(input string name);
        int diffs = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) diffs++;
        chk(name, diffs, 0);
    endtask

    // Reference: ascending word-by-word transfer on a scratch copy of memory.
    task automatic build_expected(input logic m, input logic [7:0] s, input logic [7:0] d,
                                  input logic [7:0] l, input logic [7:0] f);
        logic [7:0] scratch[256];
        logic [7:0] kk, v;
        scratch = ref_mem;
        for (int k = 0; k < int'(l); k++) begin
            kk = k[7:0];
            if (m) begin
                exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, d + kk, f});
            end else begin
                v = scratch[s + kk];
                scratch[d + kk] = v;
                exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, s + kk, 8'h00});
                exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
                exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, d + kk, v});
            end
        end
        exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
    endtask

    task automatic scramble_inputs();
        mode       = 1'($urandom);
        src_addr   = 8'($urandom);
        dst_addr   = 8'($urandom);
        length     = 8'($urandom);
        fill_value = 8'($urandom);
    endtask

    task automatic run_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input logic [7:0] f, input int extra,
                            output int lat);
        int c;
        int d0;
        @(posedge clk); #1;
        mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f; start = 1'b1;
        d0 = done_count;
        @(posedge clk); #1;
        start_cyc = cyc;
        build_expected(m, s, d, l, f);
        scramble_inputs();
        start = (extra == 1);
        c = 1;
        while (exp_q.size() > 0 && c < 2000) begin
            @(posedge clk); #1;
            c++;
            start = (c == extra);
        end
        start = 1'b0;
        chk("xfer_timeout", exp_q.size(), 0);
        exp_q.delete();
        lat = done_cyc - start_cyc + 1;
        chk("done_pulses", done_count - d0, 1);
        chk_mem("memory_image");
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    initial begin
        int lat;
        int d0;
        logic [7:0] a;
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
        for (int i = 0; i < 256; i++) preload(i[7:0], 8'($urandom));
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // Fill 0x10..0x13 with 0xA5.
        wr_log.delete();
        run_xfer(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 0, lat);
        chk("fill_latency", lat, 5);
        for (int k = 0; k < 4; k++) chk("fill_data", mem[8'h10 + k[7:0]], 8'hA5);
        chk("fill_wr_count", wr_log.size(), 4);
        for (int k = 0; k < 4; k++) chk("fill_wr_addr", wr_log[k], 8'h10 + k[7:0]);

        // Copy 0x00..0x07 -> 0x20..0x27.
        for (int k = 0; k < 8; k++) preload(k[7:0], 8'(k + 1));
        run_xfer(1'b0, 8'h00, 8'h20, 8'd8, 8'h00, 0, lat);
        chk("copy_latency", lat, 25);
        for (int k = 0; k < 8; k++) chk("copy_data", mem[8'h20 + k[7:0]], 8'(k + 1));

        // Fill wrapping past 0xFF.
        wr_log.delete();
        run_xfer(1'b1, 8'h00, 8'hFE, 8'd4, 8'h3C, 0, lat);
        chk("wrap_wr_count", wr_log.size(), 4);
        chk("wrap_addr0", wr_log[0], 8'hFE);
        chk("wrap_addr1", wr_log[1], 8'hFF);
        chk("wrap_addr2", wr_log[2], 8'h00);
        chk("wrap_addr3", wr_log[3], 8'h01);
        chk("wrap_data", mem[8'h00], 8'h3C);

        // length=0, with a start held into the DONE cycle.
        wr_log.delete();
        run_xfer(1'b1, 8'h00, 8'h50, 8'd0, 8'h77, 1, lat);
        chk("len0_latency", lat, 1);
        chk("len0_no_writes", wr_log.size(), 0);

        // Second start pulsed while busy.
        run_xfer(1'b1, 8'h00, 8'h30, 8'd6, 8'h5A, 2, lat);
        chk("busy_start_latency", lat, 7);

        // Reset during the 2nd WRITE of an 8-word copy.
        for (int k = 0; k < 8; k++) begin
            preload(8'h40 + k[7:0], 8'h80 + k[7:0]);
            preload(8'h60 + k[7:0], 8'h00);
        end
        @(posedge clk); #1;
        mode = 1'b0; src_addr = 8'h40; dst_addr = 8'h60; length = 8'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        build_expected(1'b0, 8'h40, 8'h60, 8'd8, 8'h00);
        d0 = done_count;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd", mem_read, 0);
        chk("abort_wr", mem_write, 0);
        chk("abort_word0", mem[8'h60], 8'h80);
        chk("abort_word1", mem[8'h61], 8'h00);
        chk("abort_no_done", done_count - d0, 0);
        chk_mem("abort_memory_image");
        run_xfer(1'b0, 8'h40, 8'h60, 8'd8, 8'h00, 0, lat);
        chk("restart_latency", lat, 25);
        for (int k = 0; k < 8; k++) chk("restart_data", mem[8'h60 + k[7:0]], 8'h80 + k[7:0]);

        // Overlapping forward copy propagates the first word.
        preload(8'h00, 8'h11); preload(8'h01, 8'h22); preload(8'h02, 8'h33); preload(8'h03, 8'h44);
        run_xfer(1'b0, 8'h00, 8'h01, 8'd3, 8'h00, 0, lat);
        for (int k = 1; k < 4; k++) chk("overlap_data", mem[k[7:0]], 8'h11);

        // Randomized transfers.
        for (int n = 0; n < 25; n++) begin
            logic       m;
            logic [7:0] l;
            int         ex;
            m  = 1'($urandom);
            l  = 8'($urandom_range(0, 12));
            ex = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            a  = 8'($urandom);
            run_xfer(m, a, 8'($urandom), l, 8'($urandom), ex, lat);
            chk("rand_latency", lat, (l == 0) ? 1 : (m ? int'(l) + 1 : 3 * int'(l) + 1));
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
